// File: rtl/count111_result_fifo.sv
// rtl/count111_result_fifo.sv - timestamped change-event FIFO for the 111-counter result
// Optional per-code event histogram enabled by COUNT111_RESULT_HIST_EN.
module count111_result_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               result_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W+1:0]          out_data,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef COUNT111_RESULT_HIST_EN
  ,
  output logic [31:0]              hist
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] ts;
  logic [1:0]      prev;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [TS_W+1:0] mem [DEPTH];

  logic push_req;
  logic full;
  logic pop;
  logic do_push;
  logic drop;

  assign out_level = wptr - rptr;
  assign out_valid = (out_level != '0);
  assign full      = (out_level == (AW+1)'(DEPTH));
  assign push_req  = (result_in != prev);
  assign pop       = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign out_data  = out_valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      prev     <= 2'b00;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      ts   <= ts + 1'b1;
      prev <= result_in;
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Storage needs no reset: out_data is gated by out_valid and pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= {ts, result_in};
  end

`ifdef COUNT111_RESULT_HIST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ovf_clr)
          hist[8*k +: 8] <= 8'd0;
        else if (do_push && result_in == 2'(k) && hist[8*k +: 8] != 8'hff)
          hist[8*k +: 8] <= hist[8*k +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_count111_result_fifo.sv
// tb/tb_count111_result_fifo.sv - randomized queue-model bench for count111_result_fifo
module tb_count111_result_fifo;

  localparam int DEPTH = 8;
  localparam int TS_W  = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      result_in = 2'b00;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TS_W+1:0] out_data;
  logic [3:0]      out_level;
  logic            overflow;
  logic            ovf_clr = 1'b0;
`ifdef COUNT111_RESULT_HIST_EN
  logic [31:0]     hist;
`endif

  count111_result_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result_in (result_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_level (out_level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef COUNT111_RESULT_HIST_EN
    ,
    .hist      (hist)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [TS_W+1:0] q[$];
  int              m_ts;
  logic [1:0]      m_prev;
  logic            m_ovf;
  int              m_hist[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0;
    m_prev = 2'b00;
    m_ovf = 1'b0;
    for (int k = 0; k < 4; k++) m_hist[k] = 0;
  endtask

  task automatic model_update(input logic [1:0] res, input logic rdy, input logic clr);
    bit pop_now, push_now, accepted;
    pop_now  = (q.size() != 0) && rdy;
    push_now = (res != m_prev);
    accepted = push_now && (q.size() < DEPTH || pop_now);
    if (pop_now) void'(q.pop_front());
    if (accepted) q.push_back({TS_W'(m_ts), res});
    if (push_now && !accepted) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (clr) m_hist[k] = 0;
      else if (accepted && res == 2'(k) && m_hist[k] < 255) m_hist[k]++;
    end
    m_prev = res;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_outputs();
    check("valid", 32'(out_valid), 32'(q.size() != 0));
    check("level", 32'(out_level), 32'(q.size()));
    check("data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef COUNT111_RESULT_HIST_EN
    check("hist", hist, {8'(m_hist[3]), 8'(m_hist[2]), 8'(m_hist[1]), 8'(m_hist[0])});
`endif
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic [1:0] res, input logic rdy, input logic clr);
    result_in = res;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    model_update(res, rdy, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_level", 32'(out_level), 32'd0);
    #3;
    for (int i = 0; i < n; i++) begin
      result_in = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(out_level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
    end
    rst_n = 1'b1;
    result_in = 2'b00;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    check_outputs();
  endtask

  initial begin
    int guard;
    int rp;
    int cp;
    @(negedge clk);
    do_reset(3);

    // single event after five idle cycles carries ts=5
    repeat (5) step(2'b00, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    check("single_data", 32'(out_data), 32'({12'd5, 2'b01}));

    // eight more changes: 9th event dropped
    for (int i = 0; i < 8; i++) step(m_prev + 2'd1, 1'b0, 1'b0);
    check("fill_level", 32'(out_level), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd1);

    // full with simultaneous push/pop, then clear colliding with a drop
    step(m_prev + 2'd1, 1'b1, 1'b0);
    check("full_pp_level", 32'(out_level), 32'd8);
    step(m_prev + 2'd1, 1'b0, 1'b1);
    check("set_over_clr", 32'(overflow), 32'd1);
    step(m_prev, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(m_prev, 1'b1, 1'b0);
    check("drained", 32'(out_level), 32'd0);

    // random traffic long enough to wrap the timestamp
    for (int blk = 0; blk < 12; blk++) begin
      rp = $urandom_range(5, 95);
      cp = $urandom_range(10, 90);
      for (int i = 0; i < 500; i++)
        step(($urandom_range(0, 99) < cp) ? 2'($urandom) : m_prev,
             $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 4);
    end

    // reset with five entries in flight
    guard = 0;
    while (q.size() != 5 && guard < 100) begin
      if (q.size() > 5) step(m_prev, 1'b1, 1'b0);
      else step(m_prev + 2'd1, 1'b0, 1'b0);
      guard++;
    end
    check("pre_reset_level", 32'(out_level), 32'd5);
    do_reset(2);
    repeat (4) step(2'b00, 1'b1, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    check("post_reset_data", 32'(out_data), 32'({12'd4, 2'b10}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
